// File: rtl/fmlt_wb_buffer.sv
// Write-back buffer between the FP multiplier and the register-file write port.
// Show-ahead FIFO with skid-margin stall and a sticky overflow flag for dropped results.
module fmlt_wb_buffer #(
    parameter int DEPTH       = 4,
    parameter int SKID        = 1,
    parameter int WIDTH_DATA  = 32,
    parameter int WIDTH_INDEX = 8,
    parameter int WIDTH_ISSUE = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     I_Flush,
    input  logic                     I_Valid,
    input  logic [WIDTH_DATA-1:0]    I_Data,
    input  logic [WIDTH_INDEX-1:0]   I_Index,
    input  logic [WIDTH_ISSUE-1:0]   I_Issue_No,
    output logic                     O_Stall,
    output logic                     O_WB_Valid,
    input  logic                     I_WB_Ready,
    output logic [WIDTH_DATA-1:0]    O_WB_Data,
    output logic [WIDTH_INDEX-1:0]   O_WB_Index,
    output logic [WIDTH_ISSUE-1:0]   O_WB_Issue_No,
    output logic [$clog2(DEPTH):0]   O_Count,
    output logic                     O_Overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH_DATA-1:0]  r_mem_data  [DEPTH];
    logic [WIDTH_INDEX-1:0] r_mem_index [DEPTH];
    logic [WIDTH_ISSUE-1:0] r_mem_issue [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && I_WB_Ready;
    // A pop frees the slot in the same cycle, so a full buffer can still accept.
    assign w_push  = I_Valid && (!w_full || w_pop);
    assign w_drop  = I_Valid && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (I_Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; its contents are never visible while empty.
    always_ff @(posedge clock) begin
        if (w_push && !I_Flush && !reset) begin
            r_mem_data[r_wr_ptr]  <= I_Data;
            r_mem_index[r_wr_ptr] <= I_Index;
            r_mem_issue[r_wr_ptr] <= I_Issue_No;
        end
    end

    assign O_Stall       = (r_count >= CW'(DEPTH - SKID));
    assign O_WB_Valid    = w_valid;
    assign O_WB_Data     = w_valid ? r_mem_data[r_rd_ptr]  : '0;
    assign O_WB_Index    = w_valid ? r_mem_index[r_rd_ptr] : '0;
    assign O_WB_Issue_No = w_valid ? r_mem_issue[r_rd_ptr] : '0;
    assign O_Count       = r_count;
    assign O_Overflow    = r_overflow;

endmodule

// File: tb/tb_fmlt_wb_buffer.sv
// Scoreboard bench for fmlt_wb_buffer: a queue model predicts the head, count,
// stall and overflow every cycle; entries are pushed on stimulus and popped on handshake.
module tb_fmlt_wb_buffer;

    localparam int DEPTH = 4;
    localparam int SKID  = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Flush;
    logic        I_Valid;
    logic [31:0] I_Data;
    logic [7:0]  I_Index;
    logic [5:0]  I_Issue_No;
    logic        O_Stall;
    logic        O_WB_Valid;
    logic        I_WB_Ready;
    logic [31:0] O_WB_Data;
    logic [7:0]  O_WB_Index;
    logic [5:0]  O_WB_Issue_No;
    logic [2:0]  O_Count;
    logic        O_Overflow;

    fmlt_wb_buffer #(
        .DEPTH(DEPTH), .SKID(SKID), .WIDTH_DATA(32), .WIDTH_INDEX(8), .WIDTH_ISSUE(6)
    ) dut (
        .clock(clock), .reset(reset), .I_Flush(I_Flush), .I_Valid(I_Valid),
        .I_Data(I_Data), .I_Index(I_Index), .I_Issue_No(I_Issue_No),
        .O_Stall(O_Stall), .O_WB_Valid(O_WB_Valid), .I_WB_Ready(I_WB_Ready),
        .O_WB_Data(O_WB_Data), .O_WB_Index(O_WB_Index), .O_WB_Issue_No(O_WB_Issue_No),
        .O_Count(O_Count), .O_Overflow(O_Overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  idx;
        logic [5:0]  iss;
    } entry_t;

    entry_t q[$];
    logic   m_ovf = 1'b0;
    int     n_cmp = 0;
    int     n_err = 0;
    int     max_cnt;
    int     stall_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare the registered state at negedge, advance the model.
    task automatic cycle(input logic rst, input logic flush, input logic v, input logic rdy,
                         input logic [31:0] d, input logic [7:0] idx, input logic [5:0] iss);
        entry_t e;
        bit pop;
        bit push;
        reset = rst; I_Flush = flush; I_Valid = v; I_WB_Ready = rdy;
        I_Data = d; I_Index = idx; I_Issue_No = iss;
        @(negedge clock);
        chk("count", 64'(O_Count), 64'(q.size()));
        chk("wb_valid", 64'(O_WB_Valid), 64'(q.size() != 0));
        chk("stall", 64'(O_Stall), 64'(q.size() >= DEPTH - SKID));
        chk("overflow", 64'(O_Overflow), 64'(m_ovf));
        if (q.size() != 0) begin
            chk("head_data", 64'(O_WB_Data), 64'(q[0].data));
            chk("head_index", 64'(O_WB_Index), 64'(q[0].idx));
            chk("head_issue", 64'(O_WB_Issue_No), 64'(q[0].iss));
        end else begin
            chk("gated_data", 64'(O_WB_Data), 64'd0);
            chk("gated_index", 64'(O_WB_Index), 64'd0);
            chk("gated_issue", 64'(O_WB_Issue_No), 64'd0);
        end
        if (q.size() > max_cnt) max_cnt = q.size();
        if (O_Stall) stall_seen++;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            pop  = (q.size() != 0) && rdy;
            push = v && ((q.size() < DEPTH) || pop);
            if (v && !push) begin
                m_ovf = 1'b1;
                $display("drop  iss=%0d", iss);
            end
            if (pop) begin
                $display("pop   iss=%0d idx=%0d data=%08h", q[0].iss, q[0].idx, q[0].data);
                void'(q.pop_front());
            end
            if (push) begin
                e.data = d; e.idx = idx; e.iss = iss;
                q.push_back(e);
                $display("push  iss=%0d idx=%0d data=%08h", iss, idx, d);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic rdy, input int k);
        cycle(1'b0, 1'b0, 1'b1, rdy, 32'h3F80_0000 + 32'(k), 8'(k), 6'(k));
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, 32'd0, 8'd0, 6'd0);
    endtask

    initial begin
        logic [31:0] hd;
        logic [5:0]  hi;
        reset = 1'b1; I_Flush = 1'b0; I_Valid = 1'b0; I_WB_Ready = 1'b0;
        I_Data = '0; I_Index = '0; I_Issue_No = '0;
        @(posedge clock);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 6'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 6'd0);
        idle(1'b0, 10);

        // Streaming with ready high: 1-cycle latency, occupancy never above 1.
        max_cnt = 0; stall_seen = 0;
        for (int k = 0; k < 8; k++) put(1'b1, k);
        idle(1'b1, 2);
        chk("stream_max_count", 64'(max_cnt), 64'd1);
        chk("stream_no_stall", 64'(stall_seen), 64'd0);

        // Fill with ready low, then a drop on the fifth push.
        for (int k = 0; k < 3; k++) put(1'b0, k);
        chk("stall_at_3", 64'(O_Stall), 64'd1);
        put(1'b0, 3);
        chk("count_4", 64'(O_Count), 64'd4);
        chk("no_ovf_at_4", 64'(O_Overflow), 64'd0);
        put(1'b0, 4);
        chk("ovf_after_drop", 64'(O_Overflow), 64'd1);
        chk("head_still_0", 64'(O_WB_Issue_No), 64'd0);

        // Drain to 2 entries, then flush with a simultaneous push.
        idle(1'b1, 2);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 8'd9, 6'd9);
        chk("flush_valid", 64'(O_WB_Valid), 64'd0);
        chk("flush_count", 64'(O_Count), 64'd0);
        chk("flush_keeps_ovf", 64'(O_Overflow), 64'd1);
        idle(1'b1, 2);

        // Full plus push and pop in one cycle.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 6'd0);
        for (int k = 0; k < 4; k++) put(1'b0, k);
        put(1'b1, 4);
        chk("full_pushpop_count", 64'(O_Count), 64'd4);
        chk("full_pushpop_ovf", 64'(O_Overflow), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_order", 64'(O_WB_Issue_No), 64'(k));
            idle(1'b1, 1);
        end

        // Pointer wrap across several full passes of the storage.
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) put(1'b0, 10 + 4 * p + k);
            idle(1'b1, 4);
        end

        // Back-pressure hold for 5 cycles, then pop on ready.
        put(1'b0, 33);
        put(1'b0, 34);
        hd = O_WB_Data; hi = O_WB_Issue_No;
        chk("hold_issue_start", 64'(hi), 64'd33);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 1);
            chk("hold_data", 64'(O_WB_Data), 64'(32'h3F80_0000 + 32'd33));
            chk("hold_issue", 64'(O_WB_Issue_No), 64'(hi));
        end
        idle(1'b1, 1);
        chk("pop_after_hold", 64'(O_WB_Issue_No), 64'd34);
        idle(1'b1, 2);

        // Random traffic.
        for (int i = 0; i < 80; i++)
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  $urandom, 8'($urandom), 6'(i));

        // Reset mid-stream.
        for (int k = 0; k < 3; k++) put(1'b0, 40 + k);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 8'd1, 6'd1);
        chk("reset_count", 64'(O_Count), 64'd0);
        chk("reset_stall", 64'(O_Stall), 64'd0);
        idle(1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
